bp_me_mem_cmd_arbiter: RTL
==========================

Name: bp_me_mem_cmd_arbiter

Overview:
- Shares one CCE-to-memory command/response channel (the mem link master's mem_cmd/mem_resp port) among num_req_p requesters, e.g. several CCEs or an I/O master.
- Round-robin arbitration on commands.
- Records the requester id of every issued command in an in-order tracking FIFO; memory returns responses in command order.
- Steers each response back to its originating requester.

Parameters:
- num_req_p, 4: number of requesters; must be at least 2.
- msg_width_p, "inv": width of one packed cce_mem message (header plus data), passed through unmodified.
- max_outstanding_p, 8: depth of the tracking FIFO, i.e. the number of commands in flight across all requesters; must be a power of 2.
- req_id_width_lp, `BSG_SAFE_CLOG2(num_req_p)`: localparam, requester id width.

Ports:
- clk_i  in  1  clock.
- reset_n_i  in  1  synchronous, active-low reset.
- req_cmd_i  in  num_req_p*msg_width_p  per-requester command messages; requester i occupies slice i.
- req_cmd_v_i  in  num_req_p  per-requester command valid.
- req_cmd_ready_o  out  num_req_p  per-requester ready; command i is accepted when v and ready are both high.
- req_resp_o  out  msg_width_p  response message, broadcast to all requesters.
- req_resp_v_o  out  num_req_p  one-hot response valid.
- req_resp_yumi_i  in  num_req_p  per-requester response consume.
- mem_cmd_o  out  msg_width_p  to the link master.
- mem_cmd_v_o  out  1  command valid to the link master.
- mem_cmd_ready_i  in  1  link master ready.
- mem_resp_i  in  msg_width_p  from the link master.
- mem_resp_v_i  in  1  response valid from the link master.
- mem_resp_yumi_o  out  1  response consume to the link master.
- outstanding_o  out  `BSG_WIDTH(max_outstanding_p)`  current tracking FIFO occupancy.
- err_o  out  1  sticky error: a response arrived while nothing was outstanding.

Behaviour:
- Reset (reset_n_i=0 at a clk_i edge):
  - Round-robin pointer rr_r = 0.
  - FIFO read/write pointers 0; outstanding_o = 0; err_o = 0.
  - All ready, valid and yumi outputs are 0 while reset is asserted.
  - Reset during operation discards all in-flight tracking. Any command already issued to memory is lost.
- Command arbitration (combinational, no added latency):
  - Search requesters in order rr_r, rr_r+1, ... wrapping modulo num_req_p. The grant g goes to the first requester with req_cmd_v_i set.
  - mem_cmd_v_o = |req_cmd_v_i & ~full.
  - mem_cmd_o = req_cmd_i slice g.
  - req_cmd_ready_o[g] = mem_cmd_ready_i & ~full. All other ready bits are 0.
  - The grant must not depend on mem_cmd_ready_i.
- Command handshake (mem_cmd_v_o & mem_cmd_ready_i):
  - Push g into the FIFO.
  - rr_r <= (g+1) mod num_req_p.
  - With no handshake, rr_r holds.
- Full:
  - Occupancy == max_outstanding_p blocks all issue.
  - A pop in the same cycle does not unblock issue; the push is blocked even when a pop occurs that cycle.
- Response path (combinational):
  - If mem_resp_v_i and the FIFO is not empty: req_resp_v_o = one-hot(head id), req_resp_o = mem_resp_i, mem_resp_yumi_o = req_resp_yumi_i[head].
  - The FIFO pops on mem_resp_yumi_o.
  - A yumi from a non-target requester is ignored.
- Empty with mem_resp_v_i = 1:
  - req_resp_v_o = 0 and mem_resp_yumi_o = 1: the response is dropped.
  - err_o <= 1 and stays set until reset.
- Push and pop in the same cycle (not full): occupancy is unchanged and both pointers advance, each wrapping modulo max_outstanding_p.
- outstanding_o is registered and reflects the state after the last edge.
- Assertion (simulation only): req_resp_yumi_i[i] must not be high while req_resp_v_o[i] is low.

Optional Feature:
- Macro: BP_ME_MEM_ARB_PERF_EN.
- When defined:
  - Adds output grant_cnt_o, num_req_p*32 bits: one free-running 32-bit counter per requester, incremented on each command handshake for that requester.
  - Counters reset to 0 and wrap at 2^32.
  - Adds output stall_cnt_o, 32 bits: counts cycles where |req_cmd_v_i & (full | ~mem_cmd_ready_i).
- When undefined: neither port exists and no counter logic is built.

Test Plan:
- Reset, then all four requesters valid continuously with mem_cmd_ready_i=1 and responses returned immediately -> grants 0,1,2,3,0,1,...; each response reaches the issuing requester; outstanding_o never exceeds 1.
- Only requester 2 valid for 3 cycles, then requesters 0 and 3 valid -> grants 2,2,2,3,0.
- max_outstanding_p=8, responses withheld -> 8 commands issue; the 9th is held (all ready=0) and outstanding_o=8. One response consumed -> issue resumes on the next cycle, not in the same cycle.
- Commands from requesters 1,3,1 issued, responses returned in order while req_resp_yumi_i[3] is held low for 5 cycles -> mem_resp_yumi_o=0 during the stall; delivery order is 1,3,1.
- mem_resp_v_i=1 with an empty FIFO -> mem_resp_yumi_o=1, no req_resp_v_o bit set, err_o=1 persisting until reset_n_i=0.
- With BP_ME_MEM_ARB_PERF_EN, 10 grants to requester 0 -> grant_cnt_o slice 0 = 10; reset_n_i pulse -> 0.

Source files
------------

// File: rtl/bp_me_mem_cmd_arbiter.sv
// bp_me_mem_cmd_arbiter: shares one memory command/response channel among num_req_p requesters.
// Commands are arbitrated round-robin. The id of each issued command goes into an in-order
// tracking FIFO, and each response is steered back to the requester at the FIFO head.
// Optional feature macro: BP_ME_MEM_ARB_PERF_EN adds per-requester grant counters and a
// stall-cycle counter.
module bp_me_mem_cmd_arbiter #(
  parameter int unsigned num_req_p         = 4,
  parameter int unsigned msg_width_p       = 32,
  parameter int unsigned max_outstanding_p = 8,
  localparam int unsigned req_id_width_lp  = (num_req_p > 1) ? $clog2(num_req_p) : 1,
  localparam int unsigned out_width_lp     = $clog2(max_outstanding_p + 1)
) (
  input  logic                             clk_i,
  input  logic                             reset_n_i,
  input  logic [num_req_p*msg_width_p-1:0] req_cmd_i,
  input  logic [num_req_p-1:0]             req_cmd_v_i,
  output logic [num_req_p-1:0]             req_cmd_ready_o,
  output logic [msg_width_p-1:0]           req_resp_o,
  output logic [num_req_p-1:0]             req_resp_v_o,
  input  logic [num_req_p-1:0]             req_resp_yumi_i,
  output logic [msg_width_p-1:0]           mem_cmd_o,
  output logic                             mem_cmd_v_o,
  input  logic                             mem_cmd_ready_i,
  input  logic [msg_width_p-1:0]           mem_resp_i,
  input  logic                             mem_resp_v_i,
  output logic                             mem_resp_yumi_o,
  output logic [out_width_lp-1:0]          outstanding_o,
`ifdef BP_ME_MEM_ARB_PERF_EN
  output logic [num_req_p*32-1:0]          grant_cnt_o,
  output logic [31:0]                      stall_cnt_o,
`endif
  output logic                             err_o
);

  localparam int unsigned PtrW = (max_outstanding_p > 1) ? $clog2(max_outstanding_p) : 1;
  localparam logic [num_req_p-1:0] OneHot0 = {{(num_req_p-1){1'b0}}, 1'b1};

  logic [req_id_width_lp-1:0] rr_q, rr_d;
  logic [req_id_width_lp-1:0] grant;
  logic                       any_v;
  logic [PtrW-1:0]            wptr_q, rptr_q;
  logic [out_width_lp-1:0]    count_q;
  logic                       err_q;
  logic [req_id_width_lp-1:0] fifo_q [max_outstanding_p];
  logic [req_id_width_lp-1:0] head;
  logic                       full, empty, push, pop;

  assign full  = (count_q == out_width_lp'(max_outstanding_p));
  assign empty = (count_q == '0);
  assign head  = fifo_q[rptr_q];

  // Round-robin search starting at rr_q; independent of mem_cmd_ready_i.
  always_comb begin
    grant = rr_q;
    any_v = 1'b0;
    for (int k = 0; k < int'(num_req_p); k++) begin
      if (!any_v && req_cmd_v_i[(int'(rr_q) + k) % int'(num_req_p)]) begin
        any_v = 1'b1;
        grant = req_id_width_lp'((int'(rr_q) + k) % int'(num_req_p));
      end
    end
  end

  // Command-side outputs; everything is held off while reset is asserted.
  always_comb begin
    mem_cmd_o       = req_cmd_i[int'(grant)*msg_width_p +: msg_width_p];
    mem_cmd_v_o     = reset_n_i & any_v & ~full;
    req_cmd_ready_o = '0;
    if (reset_n_i && any_v && mem_cmd_ready_i && !full) begin
      req_cmd_ready_o = OneHot0 << grant;
    end
    push = mem_cmd_v_o & mem_cmd_ready_i;
    rr_d = rr_q;
    if (push) begin
      rr_d = (int'(grant) == int'(num_req_p) - 1) ? '0 : grant + 1'b1;
    end
  end

  // Response steering; a response with nothing outstanding is consumed and dropped.
  always_comb begin
    req_resp_o      = mem_resp_i;
    req_resp_v_o    = '0;
    mem_resp_yumi_o = 1'b0;
    if (reset_n_i && mem_resp_v_i) begin
      if (!empty) begin
        req_resp_v_o    = OneHot0 << head;
        mem_resp_yumi_o = req_resp_yumi_i[head];
      end else begin
        mem_resp_yumi_o = 1'b1;
      end
    end
    pop = mem_resp_yumi_o & ~empty;
  end

  // Arbitration pointer, FIFO pointers, occupancy and sticky error.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      rr_q    <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      rr_q <= rr_d;
      if (push) wptr_q <= (wptr_q == PtrW'(max_outstanding_p - 1)) ? '0 : wptr_q + 1'b1;
      if (pop)  rptr_q <= (rptr_q == PtrW'(max_outstanding_p - 1)) ? '0 : rptr_q + 1'b1;
      if (push && !pop)      count_q <= count_q + 1'b1;
      else if (pop && !push) count_q <= count_q - 1'b1;
      if (mem_resp_v_i && empty) err_q <= 1'b1;
    end
  end

  // Tracking FIFO storage; contents are don't-care until written.
  always_ff @(posedge clk_i) begin
    if (push) fifo_q[wptr_q] <= grant;
  end

  assign outstanding_o = count_q;
  assign err_o         = err_q;

`ifdef BP_ME_MEM_ARB_PERF_EN
  logic [num_req_p-1:0][31:0] grant_cnt_q;
  logic [31:0]                stall_cnt_q;

  // Free-running performance counters, wrapping at 2^32.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      grant_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (push) grant_cnt_q[grant] <= grant_cnt_q[grant] + 32'd1;
      if (any_v && (full || !mem_cmd_ready_i)) stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign grant_cnt_o = grant_cnt_q;
  assign stall_cnt_o = stall_cnt_q;
`endif

`ifndef SYNTHESIS
  // A requester may only consume a response that is being offered to it.
  always @(posedge clk_i) begin
    if (reset_n_i) begin
      assert ((req_resp_yumi_i & ~req_resp_v_o) == '0)
        else $error("yumi asserted without matching response valid");
    end
  end
`endif

endmodule
